reset_txn_monitor: RTL and testbench

//  Synthesisable multi-channel monitor. Flags any read/write issued while a monitored reset
//  (mon_reset) is asserted, and during a programmable quiet window after its release.

---
 rtl/reset_txn_monitor_pkg.sv | 36 +++
 rtl/rmon_sat_counter.sv | 39 +++
 rtl/reset_txn_monitor.sv | 162 ++++++++++++++++
 tb/tb_reset_txn_monitor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/reset_txn_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_mon_pkg
//  Description : Shared types and helpers for the reset transaction monitor.
//                mstate_e : monitor FSM state encoding
//                viol_e   : violation kind reported with each violation
//                clog2    : width helper for the quiet-window counter
//  Revision    : 1.0  initial release
// ============================================================================
package reset_mon_pkg;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_QUIET  = 2'd1,
        ST_ACTIVE = 2'd2
    } mstate_e;

    typedef enum logic [1:0] {
        VK_NONE    = 2'd0,
        VK_IN_RST  = 2'd1,
        VK_QUIET   = 2'd2,
        VK_RW_COLL = 2'd3
    } viol_e;

    // Ceiling log2; returns 0 for v <= 1, so callers clamp to a 1-bit minimum.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : reset_mon_pkg
`default_nettype wire

// File: rtl/rmon_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : rmon_sat_counter
//  Description : Saturating up-counter with synchronous clear.
//                Clear and increment on the same edge load 1, so an event
//                coinciding with a clear is never lost.
//  Ports       : clk      - clock
//                rst_n    - synchronous active-low reset
//                i_inc    - count one event
//                i_clr    - clear count
//                o_count  - current count, holds at all-ones
//  Revision    : 1.0  initial release
// ============================================================================
module rmon_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= i_inc ? W'(1) : '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule : rmon_sat_counter
`default_nettype wire

// File: rtl/reset_txn_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : reset_txn_monitor
//  Description : Multi-channel monitor flagging read/write traffic issued while
//                a monitored reset is asserted, during a quiet window after its
//                release, and (optionally) read+write collisions per channel.
//  Ports       : clk        - clock
//                reset_n    - synchronous active-low block reset
//                mon_reset  - monitored reset (active-high)
//                read/write - per-channel strobes
//                clr_err    - clear sticky error, counter and first capture
//                viol_valid/viol_ch/viol_kind - one-cycle violation report
//                err_sticky/err_count/first_ch - accumulated error status
//                mon_state  - current FSM state
//  Revision    : 1.0  initial release
// ============================================================================
module reset_txn_monitor
    import reset_mon_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int QUIET_CYCLES = 4,
    parameter int CNT_W        = 8,
    parameter int CHK_RW_COLL  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mon_reset,
    input  logic [NUM_CH-1:0] read,
    input  logic [NUM_CH-1:0] write,
    input  logic              clr_err,
    output logic              viol_valid,
    output logic [NUM_CH-1:0] viol_ch,
    output logic [1:0]        viol_kind,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    output logic [NUM_CH-1:0] first_ch,
    output logic [1:0]        mon_state
);

    localparam int QW_RAW = clog2(QUIET_CYCLES + 1);
    localparam int QW     = (QW_RAW > 0) ? QW_RAW : 1;
    localparam logic [QW-1:0] c_QLOAD = QW'((QUIET_CYCLES > 0) ? (QUIET_CYCLES - 1) : 0);

    mstate_e           r_state;
    logic [QW-1:0]     r_qcnt;
    logic              r_valid;
    logic [NUM_CH-1:0] r_ch;
    viol_e             r_kind;
    logic              r_sticky;
    logic [NUM_CH-1:0] r_first;

    viol_e             w_kind;
    logic [NUM_CH-1:0] w_mask;
    logic              w_viol;

    // ------------------------------------------------------------------
    // FSM and quiet-window counter. The counter is loaded on release so
    // the QUIET state spans exactly QUIET_CYCLES edges.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_RST;
            r_qcnt  <= '0;
        end else begin
            case (r_state)
                ST_RST: begin
                    if (!mon_reset) begin
                        r_state <= (QUIET_CYCLES > 0) ? ST_QUIET : ST_ACTIVE;
                        r_qcnt  <= c_QLOAD;
                    end
                end
                ST_QUIET: begin
                    if (mon_reset) begin
                        r_state <= ST_RST;
                    end else if (r_qcnt == '0) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_qcnt <= r_qcnt - QW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (mon_reset) begin
                        r_state <= ST_RST;
                    end
                end
                default: begin
                    r_state <= ST_RST;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Violation check against the pre-edge state. A live mon_reset wins
    // over the state so traffic coincident with re-assertion is IN_RST.
    // ------------------------------------------------------------------
    always_comb begin
        w_kind = VK_NONE;
        w_mask = '0;
        if (mon_reset || (r_state == ST_RST)) begin
            w_kind = VK_IN_RST;
            w_mask = read | write;
        end else if (r_state == ST_QUIET) begin
            w_kind = VK_QUIET;
            w_mask = read | write;
        end else if (CHK_RW_COLL != 0) begin
            w_kind = VK_RW_COLL;
            w_mask = read & write;
        end
    end

    assign w_viol = |w_mask;

    // ------------------------------------------------------------------
    // Report and capture registers. A violation on a clearing edge is
    // treated as the first violation after the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_kind   <= VK_NONE;
            r_sticky <= 1'b0;
            r_first  <= '0;
        end else begin
            r_valid <= w_viol;
            r_ch    <= w_viol ? w_mask : '0;
            r_kind  <= w_viol ? w_kind : VK_NONE;

            if (w_viol) begin
                r_sticky <= 1'b1;
            end else if (clr_err) begin
                r_sticky <= 1'b0;
            end

            if (w_viol && (!r_sticky || clr_err)) begin
                r_first <= w_mask;
            end else if (clr_err) begin
                r_first <= '0;
            end
        end
    end

    rmon_sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_inc   (w_viol),
        .i_clr   (clr_err),
        .o_count (err_count)
    );

    assign viol_valid = r_valid;
    assign viol_ch    = r_ch;
    assign viol_kind  = r_kind;
    assign err_sticky = r_sticky;
    assign first_ch   = r_first;
    assign mon_state  = r_state;

endmodule : reset_txn_monitor
`default_nettype wire

// File: tb/tb_reset_txn_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_txn_monitor
//  Description : Self-checking bench for reset_txn_monitor (2 channels,
//                4-cycle quiet window, 2-bit error counter, collision check on).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reset_txn_monitor;

    typedef struct {
        logic       rn;
        logic       mr;
        logic [1:0] rd;
        logic [1:0] wr;
        logic       clr;
        logic       v;
        logic [1:0] ch;
        logic [1:0] kind;
        logic       s;
        logic [1:0] cnt;
        logic [1:0] first;
        logic [1:0] st;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       mon_reset;
    logic [1:0] read;
    logic [1:0] write;
    logic       clr_err;
    logic       viol_valid;
    logic [1:0] viol_ch;
    logic [1:0] viol_kind;
    logic       err_sticky;
    logic [1:0] err_count;
    logic [1:0] first_ch;
    logic [1:0] mon_state;

    int n_chk;
    int n_pass;
    int n_fail;

    vec_t tbl[$];
    vec_t sb[$];

    reset_txn_monitor #(
        .NUM_CH       (2),
        .QUIET_CYCLES (4),
        .CNT_W        (2),
        .CHK_RW_COLL  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mon_reset  (mon_reset),
        .read       (read),
        .write      (write),
        .clr_err    (clr_err),
        .viol_valid (viol_valid),
        .viol_ch    (viol_ch),
        .viol_kind  (viol_kind),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .first_ch   (first_ch),
        .mon_state  (mon_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rn, input logic mr, input logic [1:0] rd,
                                input logic [1:0] wr, input logic clr, input logic v,
                                input logic [1:0] ch, input logic [1:0] kind, input logic s,
                                input logic [1:0] cnt, input logic [1:0] first,
                                input logic [1:0] st);
        vec_t t;
        t.rn = rn; t.mr = mr; t.rd = rd; t.wr = wr; t.clr = clr;
        t.v = v; t.ch = ch; t.kind = kind; t.s = s; t.cnt = cnt; t.first = first; t.st = st;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s vec=%0d: got %0h expected %0h", name, idx, act, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    initial begin
        vec_t e;
        int   n;
        n_chk = 0; n_pass = 0; n_fail = 0;
        reset_n = 1'b0; mon_reset = 1'b1; read = '0; write = '0; clr_err = 1'b0;

        //        rn mr rd wr clr | v ch k  s cnt f st
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));  // reset
        tbl.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));  // mon_reset held
        tbl.push_back(mk(1, 1, 1, 0, 0,  1, 1, 1, 1, 1, 1, 0));  // read in reset
        tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1));  // release
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 2, 0,  1, 2, 2, 1, 2, 1, 1));  // 3rd after release
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 2, 1, 2));
        tbl.push_back(mk(1, 0, 0, 2, 0,  0, 0, 0, 1, 2, 1, 2));  // 5th: legal
        tbl.push_back(mk(1, 0, 3, 3, 0,  1, 3, 3, 1, 3, 1, 2));  // collision
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 1, 2));
        tbl.push_back(mk(1, 0, 1, 1, 0,  1, 1, 3, 1, 3, 1, 2));  // saturated
        tbl.push_back(mk(1, 0, 2, 2, 0,  1, 2, 3, 1, 3, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2));  // clr alone
        tbl.push_back(mk(1, 0, 2, 2, 1,  1, 2, 3, 1, 1, 2, 2));  // clr + viol ch1
        tbl.push_back(mk(1, 0, 1, 1, 0,  1, 1, 3, 1, 2, 2, 2));  // first held
        tbl.push_back(mk(1, 0, 1, 2, 0,  0, 0, 0, 1, 2, 2, 2));  // rd/wr diff ch
        tbl.push_back(mk(1, 1, 0, 1, 0,  1, 1, 1, 1, 3, 2, 0));  // re-assert
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 1, 2, 0, 0,  1, 2, 1, 1, 3, 2, 0));  // pulse mid-QUIET
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0,  1, 1, 2, 1, 3, 2, 2));  // last quiet edge
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 3, 2, 2));
        tbl.push_back(mk(0, 1, 3, 3, 1,  0, 0, 0, 0, 0, 0, 0));  // reset_n mid-run
        tbl.push_back(mk(1, 0, 1, 0, 0,  1, 1, 1, 1, 1, 1, 1));  // RST state, mr=0
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            reset_n   = tbl[i].rn;
            mon_reset = tbl[i].mr;
            read      = tbl[i].rd;
            write     = tbl[i].wr;
            clr_err   = tbl[i].clr;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("viol_valid", i, {7'd0, viol_valid}, {7'd0, e.v});
            chk("viol_ch",    i, {6'd0, viol_ch},    {6'd0, e.ch});
            chk("viol_kind",  i, {6'd0, viol_kind},  {6'd0, e.kind});
            chk("err_sticky", i, {7'd0, err_sticky}, {7'd0, e.s});
            chk("err_count",  i, {6'd0, err_count},  {6'd0, e.cnt});
            chk("first_ch",   i, {6'd0, first_ch},   {6'd0, e.first});
            chk("mon_state",  i, {6'd0, mon_state},  {6'd0, e.st});
        end

        // Quiet window length: from the release edge to ACTIVE is 5 edges.
        @(negedge clk);
        read = '0; write = '0; clr_err = 1'b0; mon_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
        end while ((mon_state != 2'd2) && (n < 20));
        chk("quiet_len", 99, 8'(n), 8'd5);

        chk("sb_empty", 99, 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_reset_txn_monitor
`default_nettype wire
